// File: rtl/uart_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_scheduler
// Purpose  : CPU-side sequencer for the shared UART. Queues CPU bytes in a
//            4-deep TX FIFO and hands them to the transmitter one at a time
//            via the TX_DATA/ctrl/TX_STATUS handshake. Captures received bytes
//            with overrun detection. Exposes TXD/RXD/CON registers and a
//            level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module uart_scheduler (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_STATUS,
    input  logic        TX_STATUS,
    output logic [7:0]  TX_DATA,
    output logic        ctrl,
    output logic        irqout
);

    localparam logic [31:0] c_ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] c_ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] c_ADDR_CON = 32'h4000_0020;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t      r_state;

    // TX FIFO storage and bookkeeping
    logic [7:0]  r_mem [4];
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_count;

    // Status / control flags
    logic        r_tx_done;
    logic        r_tx_ie;
    logic        r_rx_ie;
    logic        r_prev;
    logic [7:0]  r_rx_byte;
    logic        r_rx_valid;
    logic        r_overrun;

    // Bus decode and FIFO handshake
    logic        w_sel_txd;
    logic        w_sel_rxd;
    logic        w_sel_con;
    logic        w_txd_wr;
    logic        w_con_wr;
    logic        w_rxd_rd;
    logic        w_tx_empty;
    logic        w_tx_full;
    logic        w_pop;
    logic        w_push;
    logic        w_rx_evt;
    logic [31:0] w_con;
    logic        w_unused_wdata;

    assign w_sel_txd  = (addr == c_ADDR_TXD);
    assign w_sel_rxd  = (addr == c_ADDR_RXD);
    assign w_sel_con  = (addr == c_ADDR_CON);
    assign w_txd_wr   = wr & w_sel_txd;
    assign w_con_wr   = wr & w_sel_con;
    assign w_rxd_rd   = rd & w_sel_rxd;

    assign w_tx_empty = (r_count == 3'd0);
    assign w_tx_full  = (r_count == 3'd4);

    // The FSM takes the head byte only when idle and the transmitter is free.
    assign w_pop      = (r_state == S_IDLE) & ~w_tx_empty & TX_STATUS;
    // A full FIFO still accepts a push when a slot is freed in the same cycle.
    assign w_push     = w_txd_wr & (~w_tx_full | w_pop);

    assign w_rx_evt   = RX_STATUS & ~r_prev;

    assign w_con = {25'b0, w_tx_empty, r_overrun, w_tx_full, r_rx_valid,
                    r_tx_done, r_rx_ie, r_tx_ie};

    // Upper write-data bits carry no register fields.
    assign w_unused_wdata = ^wdata[31:8];

    // TX FIFO: circular buffer with wrapping 2-bit pointers and occupancy count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 8'd0;
            end
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= wdata[7:0];
                r_wptr        <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // TX sequencer: load byte, pulse ctrl, wait for busy then idle, flag done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            TX_DATA   <= 8'd0;
            ctrl      <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            ctrl <= 1'b0;
            // CPU clear comes first so a same-cycle completion overrides it.
            if (w_con_wr && wdata[2]) begin
                r_tx_done <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        TX_DATA <= r_mem[r_rptr];
                        ctrl    <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!TX_STATUS) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (TX_STATUS) begin
                        r_tx_done <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Interrupt enables written through CON
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_ie <= 1'b0;
            r_rx_ie <= 1'b0;
        end else if (w_con_wr) begin
            r_tx_ie <= wdata[0];
            r_rx_ie <= wdata[1];
        end
    end

    // RX capture: edge-detect byte-ready, hold byte, track unread and overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev     <= 1'b0;
            r_rx_byte  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_prev <= RX_STATUS;
            if (w_rx_evt) begin
                r_rx_byte  <= RX_DATA;
                r_rx_valid <= 1'b1;
            end else if (w_rxd_rd) begin
                r_rx_valid <= 1'b0;
            end
            if (w_con_wr && wdata[5]) begin
                r_overrun <= 1'b0;
            end
            // A byte arriving while the previous one is being read is not lost.
            if (w_rx_evt && r_rx_valid && !w_rxd_rd) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Combinational read mux; unmapped or idle bus reads as zero
    always_comb begin
        rdata = 32'd0;
        if (rd) begin
            if (w_sel_rxd) begin
                rdata = {24'd0, r_rx_byte};
            end else if (w_sel_con) begin
                rdata = w_con;
            end
        end
    end

    assign irqout = (r_tx_ie & r_tx_done) | (r_rx_ie & r_rx_valid);

endmodule
`default_nettype wire

// File: doc/uart_scheduler.md
# uart_scheduler

Bus-side controller that sequences the shared UART transmitter/receiver on behalf of the CPU. It holds a 4-deep TX byte FIFO and drains it one byte at a time through the UART's TX_DATA/ctrl/TX_STATUS handshake. It captures received bytes into a holding register with overrun detection. It exposes three memory-mapped registers and a level interrupt, and sits between the CPU data bus and the UART core inside the peripheral device.

## Interface
- No parameters; FIFO depth fixed at 4, addresses fixed below.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rd  in  1  CPU read strobe.
- wr  in  1  CPU write strobe.
- addr  in  32  CPU byte address.
- wdata  in  32  CPU write data.
- rdata  out  32  CPU read data; combinational, 0 when rd=0 or address unmapped.
- RX_DATA  in  8  byte from UART receiver, valid when RX_STATUS rises.
- RX_STATUS  in  1  receiver byte-ready; a 0->1 edge marks a new byte.
- TX_STATUS  in  1  transmitter idle (1) / busy (0).
- TX_DATA  out  8  byte presented to UART transmitter; registered.
- ctrl  out  1  one-cycle transmit-start pulse; registered.
- irqout  out  1  level interrupt request.

## Operation
- Register map:
  - 0x40000018 TXD: write pushes wdata[7:0] into TX FIFO; reads return 0.
  - 0x4000001C RXD: read returns {24'b0, rx_byte} and clears rx_valid.
  - 0x40000020 CON: read {25'b0, tx_empty, overrun, tx_full, rx_valid, tx_done, rx_ie, tx_ie} (bits 6..0). Write: tx_ie<=wdata[0], rx_ie<=wdata[1]; wdata[2]=1 clears tx_done; wdata[5]=1 clears overrun.
- TX FIFO: 4 entries, 2-bit read/write pointers wrap 3->0, 3-bit count. Push accepted when count<4, or when count=4 and a pop occurs in the same cycle. Otherwise the write is dropped with no flag. tx_full = (count==4), tx_empty = (count==0).
- TX FSM, states IDLE, START, WAIT_BUSY, WAIT_DONE:
  - IDLE: if FIFO non-empty and TX_STATUS=1, load TX_DATA<=head, pop, go to START.
  - START: ctrl=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: stay until TX_STATUS=0, then go to WAIT_DONE.
  - WAIT_DONE: stay until TX_STATUS=1; then set tx_done=1 and go to IDLE.
- RX path: RX_STATUS is registered once to prev; rx_evt = RX_STATUS & ~prev. On rx_evt, rx_byte<=RX_DATA and rx_valid<=1. If rx_valid was already 1 and it is not being cleared by an RXD read in the same cycle, overrun<=1.
- rx_evt coincident with an RXD read: the read returns the old byte, the new byte is stored, rx_valid stays 1, and overrun is not set.
- tx_done set by the FSM and cleared by a CON write in the same cycle: set wins.
- irqout = (tx_ie & tx_done) | (rx_ie & rx_valid).
- Read side effects apply only when rd=1 and addr matches; wr and rd are never both asserted by the CPU, so no priority is defined between them.

## Timing
- Reset values: TX_DATA=0, ctrl=0, irqout=0, FSM=IDLE, FIFO empty, pointers 0, rx_byte=0, all flags and enables 0, prev=0.
- Reset mid-transfer: the FSM returns to IDLE immediately and FIFO contents are discarded. No ctrl pulse is issued after reset is asserted.
- Write latency: TXD write in cycle 0 with FSM idle and TX_STATUS=1 gives count=1 in cycle 1, START in cycle 2 (ctrl=1, TX_DATA valid), and ctrl=0 in cycle 3.
- TX_DATA is stable from START until the next IDLE->START load.
- Back-to-back bytes: the next START occurs no earlier than 2 cycles after TX_STATUS returns to 1.
- RX: a RX_STATUS rise in cycle n sets rx_valid visible in cycle n+1, with irqout following in the same cycle as rx_valid.
- rdata reflects register state in the same cycle as rd.

## Test plan
- Reset then single TX: write 0x41 to TXD; model TX_STATUS busy 10 cycles after ctrl -> ctrl pulses 1 cycle in cycle 2, TX_DATA=0x41, tx_done=1 after TX_STATUS returns, CON read bit2=1.
- FIFO fill/overflow: hold TX_STATUS=0, write 0x01..0x05 -> tx_full=1 after 4 writes, 0x05 dropped. Release TX_STATUS -> bytes 0x01,0x02,0x03,0x04 sent in order, tx_empty=1 at end.
- RX and overrun: pulse RX_STATUS with 0x5A, then 0xA5 without reading -> RXD read = 0xA5, overrun=1, rx_valid=0 after read. Write CON 0x20 -> overrun=0.
- Simultaneous read/receive: RXD read in the same cycle as a RX_STATUS rise with 0x33 -> read returns old byte, rx_valid stays 1, overrun=0, next RXD read = 0x33.
- Interrupt: set CON=0x3, complete one TX -> irqout=1. Write CON 0x07 -> irqout=0. Receive a byte -> irqout=1 until RXD read.
- Async reset during WAIT_DONE with 2 bytes queued -> all outputs 0 immediately, no further ctrl pulses after release.
